// File: rtl/key_schedule_seq.sv
// Purpose : sequential AES key expansion, one Nk-word step per clock, all Nr+1 round keys buffered.
// Latency : start accepted at edge 0, busy for S steps, done pulses on READY entry; rdKey is 1-cycle registered.
// Backpres: none; start is ignored while an expansion runs, reads return zero until the schedule is complete.
//
// Ports:
//   i_clk       clock, all state on rising edge
//   i_reset     synchronous active-high reset (FSM, counters, outputs)
//   i_start     request a new expansion (honoured in IDLE or READY)
//   i_keyIn     cipher key, 32*Nk bits, word 0 in the MSBs
//   o_busy      expansion in progress
//   o_done      one-cycle pulse when the schedule becomes complete
//   o_keyReady  buffer holds a complete schedule for the last accepted key
//   i_rdRound   round-key index 0..Nr
//   o_rdKey     registered round key, word 4*rdRound in the MSBs; zero when not ready or out of range
module key_schedule_seq #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [32*Nk-1:0]  i_keyIn,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_keyReady,
  input  logic [3:0]        i_rdRound,
  output logic [127:0]      o_rdKey
);

  // Total words in the schedule and number of expansion steps needed to cover
  // words Nk..W-1 (the last step may overrun W; those words are dropped).
  localparam int         W    = 4 * (Nr + 1);
  localparam int         S    = (W - 1) / Nk;
  localparam int         AW   = $clog2(W);
  localparam logic [3:0] S_L  = 4'(S);
  localparam logic [3:0] NR_L = 4'(Nr);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers and the AES S-box, built from inversion + affine map so no
  // 256-entry table is needed.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (addition chain 3,7,15,31,63,127,254);
  // maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x3, x7, x15, x31, x63, x127, inv;
    x3   = gf_mul(gf_mul(a, a), a);
    x7   = gf_mul(gf_mul(x3, x3), a);
    x15  = gf_mul(gf_mul(x7, x7), a);
    x31  = gf_mul(gf_mul(x15, x15), a);
    x63  = gf_mul(gf_mul(x31, x31), a);
    x127 = gf_mul(gf_mul(x63, x63), a);
    inv  = gf_mul(x127, x127);
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_step;
  logic [7:0]   r_rcon;
  logic         r_done;
  logic         r_keyReady;
  logic [127:0] r_rdKey;

  // Last Nk words produced; the step datapath works from this copy rather than
  // through a wide read mux on the buffer.
  logic [31:0]  r_prev  [Nk];
  logic [31:0]  r_words [W];

  logic         w_accept;
  logic         w_step;
  logic         w_last;
  logic [31:0]  w_key_words [Nk];
  logic [31:0]  w_new       [Nk];
  logic [31:0]  w_acc;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE, ST_READY: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        w_step = 1'b1;
        if (r_step == S_L) begin
          w_last      = 1'b1;
          w_state_nxt = ST_READY;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Step counter, rcon and status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_step     <= 4'd0;
      r_rcon     <= 8'h00;
      r_done     <= 1'b0;
      r_keyReady <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_step     <= 4'd1;
        r_rcon     <= 8'h01;
        r_keyReady <= 1'b0;
      end else if (w_step) begin
        if (w_last) begin
          r_step     <= 4'd0;
          r_keyReady <= 1'b1;
        end else begin
          r_step <= r_step + 4'd1;
          r_rcon <= xtime(r_rcon);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-step datapath: a ripple through the Nk words of one step.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < Nk; g++) begin : g_key
    assign w_key_words[g] = i_keyIn[32*(Nk-g)-1 -: 32];
  end

  always_comb begin
    for (int i = 0; i < Nk; i++) w_new[i] = 32'h0;
    w_acc    = r_prev[0] ^ sub_word(rot_word(r_prev[Nk-1])) ^ {r_rcon, 24'h0};
    w_new[0] = w_acc;
    for (int i = 1; i < Nk; i++) begin
      // 256-bit keys insert an extra SubWord halfway through each step.
      if (Nk == 8 && i == 4) w_acc = r_prev[i] ^ sub_word(w_acc);
      else                   w_acc = r_prev[i] ^ w_acc;
      w_new[i] = w_acc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      for (int i = 0; i < Nk; i++) r_prev[i] <= w_key_words[i];
    end else if (w_step) begin
      for (int i = 0; i < Nk; i++) r_prev[i] <= w_new[i];
    end
  end

  // Word j belongs to step j/Nk at lane j%Nk, so each entry has a fixed write
  // strobe; entries past W-1 simply do not exist.
  always_ff @(posedge i_clk) begin
    for (int j = 0; j < W; j++) begin
      if (j < Nk) begin
        if (w_accept) r_words[j] <= w_key_words[j % Nk];
      end else if (w_step && (r_step == 4'(j / Nk))) begin
        r_words[j] <= w_new[j % Nk];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read port. Out-of-range indices are clamped before addressing the buffer
  // (the result is zeroed anyway). A read landing on the accept edge is also
  // zeroed, since the buffer is being overwritten from that edge on.
  // ---------------------------------------------------------------------------
  logic [3:0]    w_rd_sel;
  logic [AW-1:0] w_rd_base;
  logic          w_rd_ok;

  assign w_rd_ok   = r_keyReady && !w_accept && (i_rdRound <= NR_L);
  assign w_rd_sel  = (i_rdRound <= NR_L) ? i_rdRound : 4'd0;
  assign w_rd_base = AW'({w_rd_sel, 2'b00});

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdKey <= 128'h0;
    end else if (w_rd_ok) begin
      r_rdKey <= {r_words[w_rd_base],
                  r_words[w_rd_base + AW'(1)],
                  r_words[w_rd_base + AW'(2)],
                  r_words[w_rd_base + AW'(3)]};
    end else begin
      r_rdKey <= 128'h0;
    end
  end

  assign o_busy     = (r_state == ST_EXPAND);
  assign o_done     = r_done;
  assign o_keyReady = r_keyReady;
  assign o_rdKey    = r_rdKey;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Bench for key_schedule_seq: three instances (Nk=4/6/8) driven from one directed
// sequence, checked against known-answer vectors and a FIPS-197 style expansion model.
module tb_key_schedule_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [2:0]   start_v;
  logic [255:0] key_v  [3];
  logic [3:0]   rd_v   [3];
  logic [2:0]   busy_v;
  logic [2:0]   done_v;
  logic [2:0]   kr_v;
  logic [127:0] rdk_v  [3];

  key_schedule_seq #(.Nk(4), .Nr(10)) u_nk4 (
    .i_clk(clk), .i_reset(rst), .i_start(start_v[0]), .i_keyIn(key_v[0][255 -: 128]),
    .o_busy(busy_v[0]), .o_done(done_v[0]), .o_keyReady(kr_v[0]),
    .i_rdRound(rd_v[0]), .o_rdKey(rdk_v[0]));

  key_schedule_seq #(.Nk(6), .Nr(12)) u_nk6 (
    .i_clk(clk), .i_reset(rst), .i_start(start_v[1]), .i_keyIn(key_v[1][255 -: 192]),
    .o_busy(busy_v[1]), .o_done(done_v[1]), .o_keyReady(kr_v[1]),
    .i_rdRound(rd_v[1]), .o_rdKey(rdk_v[1]));

  key_schedule_seq #(.Nk(8), .Nr(14)) u_nk8 (
    .i_clk(clk), .i_reset(rst), .i_start(start_v[2]), .i_keyIn(key_v[2]),
    .o_busy(busy_v[2]), .o_done(done_v[2]), .o_keyReady(kr_v[2]),
    .i_rdRound(rd_v[2]), .o_rdKey(rdk_v[2]));

  int total = 0;
  int bad   = 0;

  localparam int         NK_OF   [3]  = '{4, 6, 8};
  localparam int         NR_OF   [3]  = '{10, 12, 14};
  localparam int         EXP_CYC [3]  = '{11, 9, 8};
  localparam logic [7:0] RCON    [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [3][15];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (x != 0 && m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] m_subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic model_expand(input int d, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    int nk = NK_OF[d];
    int nr = NR_OF[d];
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0)                t = m_subw({t[23:0], t[31:24]}) ^ {RCON[i/nk-1], 24'h0};
      else if (nk > 6 && i % nk == 4) t = m_subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) exp_rk[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus helpers ----------------
  // Called at #1 after an edge. Returns at #1 after the edge on which done is seen.
  task automatic run_expand(input int d, input logic [255:0] key, input bit poke, input string tag);
    int cyc = 0;
    bit seen = 0;
    key_v[d] = key;
    model_expand(d, key);
    start_v[d] = 1'b1;
    while (!seen && cyc < 40) begin
      rd_v[d] = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      cyc++;
      start_v[d] = poke && (cyc == 3 || cyc == 5);
      if (cyc == 1) begin
        chk($sformatf("%s_busy_after_start", tag), {127'h0, busy_v[d]}, 128'h1);
        chk($sformatf("%s_keyready_drop", tag), {127'h0, kr_v[d]}, 128'h0);
      end
      if (busy_v[d]) chk($sformatf("%s_read_while_busy", tag), rdk_v[d], 128'h0);
      if (done_v[d]) seen = 1;
    end
    start_v[d] = 1'b0;
    chk($sformatf("%s_done_latency", tag), 128'(cyc), 128'(EXP_CYC[d]));
    chk($sformatf("%s_keyready_at_done", tag), {127'h0, kr_v[d]}, 128'h1);
  endtask

  task automatic read_chk(input int d, input int round, input logic [127:0] exp, input string tag);
    rd_v[d] = 4'(round);
    @(posedge clk); #1;
    chk($sformatf("%s_rd%0d", tag, round), rdk_v[d], exp);
  endtask

  localparam logic [255:0] KEY4 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY6 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    logic [255:0] rk;
    int           ndone;

    build_sbox();
    rst     = 1'b1;
    start_v = 3'b000;
    for (int d = 0; d < 3; d++) begin
      key_v[d] = 256'h0;
      rd_v[d]  = 4'd0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_busy_%0d", d), {127'h0, busy_v[d]}, 128'h0);
      chk($sformatf("reset_done_%0d", d), {127'h0, done_v[d]}, 128'h0);
      chk($sformatf("reset_keyready_%0d", d), {127'h0, kr_v[d]}, 128'h0);
      chk($sformatf("reset_rdkey_%0d", d), rdk_v[d], 128'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-answer vectors
    run_expand(0, KEY4, 1'b0, "kat4");
    read_chk(0, 1, 128'ha0fafe1788542cb123a339392a6c7605, "kat4");
    chk("kat4_done_one_cycle", {127'h0, done_v[0]}, 128'h0);
    read_chk(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "kat4");
    read_chk(0, 11, 128'h0, "kat4_oob");
    read_chk(0, 0, exp_rk[0][0], "kat4_model");

    run_expand(1, KEY6, 1'b0, "kat6");
    read_chk(1, 12, 128'he98ba06f448c773c8ecc720401002202, "kat6");
    read_chk(1, 13, 128'h0, "kat6_oob");

    run_expand(2, KEY8, 1'b0, "kat8");
    read_chk(2, 14, 128'hfe4890d1e6188d0b046df344706c631e, "kat8");
    read_chk(2, 15, 128'h0, "kat8_oob");

    // start pulses during EXPAND are ignored
    run_expand(0, KEY4, 1'b1, "poke4");
    read_chk(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "poke4");

    // Reset at cycle 5 of EXPAND
    key_v[0]   = KEY4;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", {127'h0, busy_v[0]}, 128'h0);
    chk("midrst_keyready", {127'h0, kr_v[0]}, 128'h0);
    chk("midrst_done", {127'h0, done_v[0]}, 128'h0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done_v[0] || busy_v[0]) ndone++;
    end
    chk("midrst_no_done_no_busy", 128'(ndone), 128'h0);
    run_expand(0, KEY4, 1'b0, "rerun4");
    read_chk(0, 1, 128'ha0fafe1788542cb123a339392a6c7605, "rerun4");
    read_chk(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "rerun4");

    // Back-to-back: new start on the cycle right after done
    run_expand(0, KEY4, 1'b0, "b2b_a");
    rk = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    run_expand(0, rk, 1'b0, "b2b_b");
    read_chk(0, 0, rk[255:128], "b2b_round0");
    read_chk(0, 10, exp_rk[0][10], "b2b_model");

    // Randomized keys, every round checked against the model
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 2; n++) begin
        rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run_expand(d, rk, n[0], $sformatf("rnd_nk%0d_%0d", NK_OF[d], n));
        for (int r = 0; r <= NR_OF[d]; r++)
          read_chk(d, r, exp_rk[d][r], $sformatf("rnd_nk%0d_%0d", NK_OF[d], n));
        read_chk(d, $urandom_range(NR_OF[d] + 1, 15), 128'h0, $sformatf("rnd_oob_nk%0d", NK_OF[d]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
